// File: rtl/msg_loader.sv
// rtl/msg_loader.sv - assembles a character stream into a fixed-size message buffer
// Index 0 lands in the most-significant character slot; bytes not written read zero.
module msg_loader #(
    parameter int MESSAGE_LENGTH = 160,
    parameter int CHAR_LENGTH    = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [CHAR_LENGTH-1:0]                in_char,
    input  logic                                  in_last,
    output logic [CHAR_LENGTH*MESSAGE_LENGTH-1:0] msg,
    output logic [7:0]                            length,
    output logic                                  msg_valid,
    input  logic                                  msg_ready,
    output logic                                  overflow
);

    localparam int IDX_W = (MESSAGE_LENGTH > 1) ? $clog2(MESSAGE_LENGTH) : 1;
    localparam logic [7:0] MAX_LEN = 8'(MESSAGE_LENGTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD
    } state_t;

    state_t                 state;
    logic [CHAR_LENGTH-1:0] buffer [MESSAGE_LENGTH];
    logic                   xfer;

    assign xfer = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            msg_valid <= 1'b0;
            length    <= '0;
            overflow  <= 1'b0;
            for (int i = 0; i < MESSAGE_LENGTH; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is registered, so it first rises one edge after reset release
                    in_ready <= 1'b1;
                    if (xfer) begin
                        for (int i = 1; i < MESSAGE_LENGTH; i++) begin
                            buffer[i] <= '0;
                        end
                        buffer[0] <= in_char;
                        length    <= 8'd1;
                        overflow  <= 1'b0;
                        if (in_last) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            msg_valid <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        // A full buffer drops further characters and flags the message
                        if (length < MAX_LEN) begin
                            buffer[length[IDX_W-1:0]] <= in_char;
                            length                    <= length + 8'd1;
                        end else begin
                            overflow <= 1'b1;
                        end
                        if (in_last) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            msg_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (msg_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        msg_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    msg_valid <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < MESSAGE_LENGTH; i++) begin : g_pack
        assign msg[CHAR_LENGTH*(MESSAGE_LENGTH-i)-1 -: CHAR_LENGTH] = buffer[i];
    end

endmodule
